// File: rtl/acorn_ctrl_pkg.sv
// rtl/acorn_ctrl_pkg.sv - ACORN-128 phase codes, default step counts and per-phase ca/cb rule
package acorn_ctrl_pkg;

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_INIT    = 3'd1;
  localparam logic [2:0] PH_AD      = 3'd2;
  localparam logic [2:0] PH_AD_PAD  = 3'd3;
  localparam logic [2:0] PH_MSG     = 3'd4;
  localparam logic [2:0] PH_MSG_PAD = 3'd5;
  localparam logic [2:0] PH_FINAL   = 3'd6;

  localparam int DEF_INIT_STEPS  = 1792;
  localparam int DEF_PAD_STEPS   = 256;
  localparam int DEF_FINAL_STEPS = 768;
  localparam int DEF_BLK_BITS    = 128;

  // Step counter covers the 1792-step init phase with one spare bit.
  localparam int STEP_W = 12;

  // Pad phases keep ca high only for their first 128 steps.
  localparam logic [STEP_W-1:0] PAD_CA_STEPS = 12'd128;

  function automatic logic [1:0] phase_ca_cb(input logic [2:0] phase,
                                             input logic [STEP_W-1:0] step_idx);
    logic early;
    early = (step_idx < PAD_CA_STEPS);
    case (phase)
      PH_INIT, PH_AD, PH_FINAL: phase_ca_cb = 2'b11;
      PH_AD_PAD:                phase_ca_cb = {early, 1'b1};
      PH_MSG:                   phase_ca_cb = 2'b10;
      PH_MSG_PAD:               phase_ca_cb = {early, 1'b0};
      default:                  phase_ca_cb = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/acorn_phase_counter.sv
// rtl/acorn_phase_counter.sv - loadable cycle down-counter with last-cycle flag and UNROLL-scaled step index
module acorn_phase_counter
  import acorn_ctrl_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STEP_W-1:0] load_cycles,
  input  logic              en,
  output logic              last,
  output logic [STEP_W-1:0] step_idx
);

  localparam logic [STEP_W-1:0] UNROLL_W = STEP_W'(UNROLL);
  localparam logic [STEP_W-1:0] ONE      = 12'd1;

  logic [STEP_W-1:0] rem_q;
  logic [STEP_W-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      rem_q <= load_cycles;
      idx_q <= '0;
    end else if (en && (rem_q != '0)) begin
      rem_q <= rem_q - ONE;
      idx_q <= idx_q + ONE;
    end
  end

  assign last     = (rem_q == ONE);
  assign step_idx = idx_q * UNROLL_W;

endmodule

// File: rtl/acorn_phase_ctrl.sv
// rtl/acorn_phase_ctrl.sv - ACORN-128 phase sequencer: init, AD, pads, message, final with block handshake
module acorn_phase_ctrl
  import acorn_ctrl_pkg::*;
#(
  parameter int UNROLL      = 1,
  parameter int LEN_W       = 16,
  parameter int INIT_STEPS  = DEF_INIT_STEPS,
  parameter int PAD_STEPS   = DEF_PAD_STEPS,
  parameter int FINAL_STEPS = DEF_FINAL_STEPS,
  parameter int BLK_BITS    = DEF_BLK_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic             mode_in,
  input  logic [LEN_W-1:0] ad_blocks_in,
  input  logic [LEN_W-1:0] msg_blocks_in,
  input  logic             blk_valid_in,
  output logic             blk_ready_out,
  output logic             step_en_out,
  output logic             ca_out,
  output logic             cb_out,
  output logic             pad_one_out,
  output logic             decrypt_out,
  output logic [2:0]       phase_out,
  output logic [11:0]      step_idx_out,
  output logic             busy_out,
  output logic             tag_valid_out
);

  localparam logic [STEP_W-1:0] INIT_CYC  = STEP_W'(INIT_STEPS / UNROLL);
  localparam logic [STEP_W-1:0] PAD_CYC   = STEP_W'(PAD_STEPS / UNROLL);
  localparam logic [STEP_W-1:0] FINAL_CYC = STEP_W'(FINAL_STEPS / UNROLL);
  localparam logic [STEP_W-1:0] BLK_CYC   = STEP_W'(BLK_BITS / UNROLL);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  logic [2:0]        phase_q, phase_d;
  logic              mode_q, blk_busy_q, tag_q;
  logic [LEN_W-1:0]  ad_rem_q, msg_rem_q;
  logic              cnt_load, cnt_last;
  logic [STEP_W-1:0] cnt_val, step_idx;
  logic              in_blk, counted, step_en, blk_xfer, phase_end;
  logic [1:0]        ctrl_bits;

  assign in_blk    = (phase_q == PH_AD) || (phase_q == PH_MSG);
  assign counted   = (phase_q == PH_INIT) || (phase_q == PH_AD_PAD) ||
                     (phase_q == PH_MSG_PAD) || (phase_q == PH_FINAL);
  assign step_en   = counted || (in_blk && blk_busy_q);
  assign blk_xfer  = in_blk && !blk_busy_q && blk_valid_in;
  assign phase_end = step_en && cnt_last;

  // One shared counter, reloaded at every phase or block boundary.
  always_comb begin
    phase_d  = phase_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (abort_in) begin
      phase_d  = PH_IDLE;
      cnt_load = 1'b1;
    end else if (phase_q == PH_IDLE) begin
      if (start_in) begin
        phase_d  = PH_INIT;
        cnt_load = 1'b1;
        cnt_val  = INIT_CYC;
      end
    end else if (blk_xfer) begin
      cnt_load = 1'b1;
      cnt_val  = BLK_CYC;
    end else if (phase_end) begin
      cnt_load = 1'b1;
      case (phase_q)
        PH_INIT: begin
          phase_d = (ad_rem_q != '0) ? PH_AD : PH_AD_PAD;
          cnt_val = (ad_rem_q != '0) ? BLK_CYC : PAD_CYC;
        end
        PH_AD: begin
          phase_d = (ad_rem_q <= LEN_ONE) ? PH_AD_PAD : PH_AD;
          cnt_val = (ad_rem_q <= LEN_ONE) ? PAD_CYC : BLK_CYC;
        end
        PH_AD_PAD: begin
          phase_d = (msg_rem_q != '0) ? PH_MSG : PH_MSG_PAD;
          cnt_val = (msg_rem_q != '0) ? BLK_CYC : PAD_CYC;
        end
        PH_MSG: begin
          phase_d = (msg_rem_q <= LEN_ONE) ? PH_MSG_PAD : PH_MSG;
          cnt_val = (msg_rem_q <= LEN_ONE) ? PAD_CYC : BLK_CYC;
        end
        PH_MSG_PAD: begin
          phase_d = PH_FINAL;
          cnt_val = FINAL_CYC;
        end
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_IDLE;
      mode_q     <= 1'b0;
      blk_busy_q <= 1'b0;
      tag_q      <= 1'b0;
      ad_rem_q   <= '0;
      msg_rem_q  <= '0;
    end else begin
      phase_q <= phase_d;
      tag_q   <= !abort_in && phase_end && (phase_q == PH_FINAL);
      if (abort_in) begin
        mode_q     <= 1'b0;
        blk_busy_q <= 1'b0;
        ad_rem_q   <= '0;
        msg_rem_q  <= '0;
      end else begin
        if ((phase_q == PH_IDLE) && start_in) begin
          mode_q    <= mode_in;
          ad_rem_q  <= ad_blocks_in;
          msg_rem_q <= msg_blocks_in;
        end
        if (blk_xfer) begin
          blk_busy_q <= 1'b1;
        end else if (phase_end && in_blk) begin
          blk_busy_q <= 1'b0;
          if ((phase_q == PH_AD) && (ad_rem_q != '0)) ad_rem_q <= ad_rem_q - LEN_ONE;
          if ((phase_q == PH_MSG) && (msg_rem_q != '0)) msg_rem_q <= msg_rem_q - LEN_ONE;
        end
      end
    end
  end

  acorn_phase_counter #(.UNROLL(UNROLL)) u_counter (
    .clk         (clk),
    .rst         (rst),
    .load        (cnt_load),
    .load_cycles (cnt_val),
    .en          (step_en),
    .last        (cnt_last),
    .step_idx    (step_idx)
  );

  assign ctrl_bits     = phase_ca_cb(phase_q, step_idx);
  assign blk_ready_out = in_blk && !blk_busy_q;
  assign step_en_out   = step_en;
  assign ca_out        = step_en && ctrl_bits[1];
  assign cb_out        = step_en && ctrl_bits[0];
  assign pad_one_out   = ((phase_q == PH_AD_PAD) || (phase_q == PH_MSG_PAD)) && (step_idx == '0);
  assign decrypt_out   = mode_q;
  assign phase_out     = phase_q;
  assign step_idx_out  = step_idx;
  assign busy_out      = (phase_q != PH_IDLE);
  assign tag_valid_out = tag_q;

endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// tb/tb_acorn_phase_ctrl.sv - self-checking bench for acorn_phase_ctrl at UNROLL 1, 4 and 8
module tb_acorn_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic        abort_in = 1'b0;
  logic        mode_in = 1'b0;
  logic        blk_valid_in = 1'b0;
  logic [15:0] ad_blocks_in = '0;
  logic [15:0] msg_blocks_in = '0;
  int          sel = 0;
  logic [2:0]  start_vec;
  logic [22:0] obs_arr [3];
  logic [22:0] obs;

  // Observation word: {ready, step_en, ca, cb, pad, dec, phase[2:0], idx[11:0], busy, tag}
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int U = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    logic rdy, sen, ca, cb, pad, dec, busy, tag;
    logic [2:0]  ph;
    logic [11:0] idx;
    acorn_phase_ctrl #(.UNROLL(U)) dut (
      .clk(clk), .rst(rst), .start_in(start_vec[g]), .abort_in(abort_in),
      .mode_in(mode_in), .ad_blocks_in(ad_blocks_in), .msg_blocks_in(msg_blocks_in),
      .blk_valid_in(blk_valid_in), .blk_ready_out(rdy), .step_en_out(sen),
      .ca_out(ca), .cb_out(cb), .pad_one_out(pad), .decrypt_out(dec),
      .phase_out(ph), .step_idx_out(idx), .busy_out(busy), .tag_valid_out(tag)
    );
    assign obs_arr[g] = {rdy, sen, ca, cb, pad, dec, ph, idx, busy, tag};
  end

  assign start_vec = {start_in && (sel == 2), start_in && (sel == 1), start_in && (sel == 0)};
  assign obs = obs_arr[sel];

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Trace entry: {drive start, drive abort, drive blk_valid, expected observation}
  logic [25:0] trace [$];
  int   cur_u = 1;
  logic cur_dec = 1'b0;
  int   n_step, n_tag, tag_cyc, n_adpad_ca, n_pad, n_msg_step, n_msg_cb, n_wait;

  function automatic logic [22:0] ob(input logic rdy, input logic sen, input logic ca,
                                     input logic cb, input logic pad, input logic dec,
                                     input logic [2:0] ph, input int idx,
                                     input logic busy, input logic tag);
    logic [11:0] i12;
    i12 = idx[11:0];
    return {rdy, sen, ca, cb, pad, dec, ph, i12, busy, tag};
  endfunction

  task automatic chk_vec(input string name, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pin(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input logic st, input logic ab, input logic vl, input logic [22:0] e);
    trace.push_back({st, ab, vl, e});
  endtask

  task automatic add_idle(input logic st, input logic dec);
    push(st, 1'b0, 1'b0, ob(0, 0, 0, 0, 0, dec, 3'd0, 0, 0, 0));
  endtask

  // Counted phase: every cycle steps; pads hold ca for steps below 128, only MSG_PAD has cb low.
  task automatic add_counted(input logic [2:0] ph, input int steps, input int abort_at);
    logic is_pad, ca, cb;
    int idx;
    is_pad = (ph == 3'd3) || (ph == 3'd5);
    cb = (ph != 3'd5);
    for (int k = 0; k < steps / cur_u; k++) begin
      idx = k * cur_u;
      ca  = is_pad ? (idx < 128) : 1'b1;
      push(1'b0, k == abort_at, 1'b1, ob(0, 1, ca, cb, is_pad && (k == 0), cur_dec, ph, idx, 1, 0));
      if (k == abort_at) return;
    end
  endtask

  task automatic add_block(input logic [2:0] ph, input int stall);
    for (int s = 0; s < stall; s++) push(1'b0, 1'b0, 1'b0, ob(1, 0, 0, 0, 0, cur_dec, ph, 0, 1, 0));
    push(1'b0, 1'b0, 1'b1, ob(1, 0, 0, 0, 0, cur_dec, ph, 0, 1, 0));
    for (int k = 0; k < 128 / cur_u; k++)
      push(1'b0, 1'b0, 1'b1, ob(0, 1, 1, ph == 3'd2, 0, cur_dec, ph, k * cur_u, 1, 0));
  endtask

  task automatic add_run(input int ad, input int msg, input int msg_stall);
    add_counted(3'd1, 1792, -1);
    for (int b = 0; b < ad; b++) add_block(3'd2, 0);
    add_counted(3'd3, 256, -1);
    for (int b = 0; b < msg; b++) add_block(3'd4, (b == 0) ? msg_stall : 0);
    add_counted(3'd5, 256, -1);
    add_counted(3'd6, 768, -1);
    push(1'b0, 1'b0, 1'b0, ob(0, 0, 0, 0, 0, cur_dec, 3'd0, 0, 0, 1));
    add_idle(1'b0, cur_dec);
  endtask

  task automatic run_trace();
    logic [22:0] got;
    n_step = 0; n_tag = 0; tag_cyc = -1; n_adpad_ca = 0; n_pad = 0;
    n_msg_step = 0; n_msg_cb = 0; n_wait = 0;
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clk);
      got = obs;
      chk_vec($sformatf("trace_u%0d_cyc%0d", cur_u, i), got, trace[i][22:0]);
      if (got[21]) n_step++;
      if (got[0]) begin n_tag++; tag_cyc = i; end
      if (got[16:14] == 3'd3 && got[21] && got[20]) n_adpad_ca++;
      if (got[18]) n_pad++;
      if (got[16:14] == 3'd4 && got[21]) begin n_msg_step++; if (got[19]) n_msg_cb++; end
      if (got[22] && !got[21]) n_wait++;
      start_in     = trace[i][25];
      abort_in     = trace[i][24];
      blk_valid_in = trace[i][23];
    end
    start_in = 1'b0; abort_in = 1'b0; blk_valid_in = 1'b0;
    trace.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) chk_vec($sformatf("reset_state_dut%0d", g), obs_arr[g], 23'd0);
    rst = 1'b0;

    // UNROLL=1, no blocks, encrypt
    sel = 0; cur_u = 1; mode_in = 1'b0; cur_dec = 1'b0;
    ad_blocks_in = 16'd0; msg_blocks_in = 16'd0;
    add_idle(1'b1, 1'b0);
    add_run(0, 0, 0);
    run_trace();
    pin("u1_tag_cycle", tag_cyc, 3073);
    pin("u1_step_count", n_step, 3072);
    pin("u1_adpad_ca_steps", n_adpad_ca, 128);
    pin("u1_pad_one_count", n_pad, 2);

    // UNROLL=8, ad=2 msg=3, stray start pulse inside AD
    sel = 2; cur_u = 8; ad_blocks_in = 16'd2; msg_blocks_in = 16'd3;
    add_idle(1'b1, 1'b0);
    add_run(2, 3, 0);
    trace[230][25] = 1'b1;
    run_trace();
    pin("u8_blocks_tag_cycle", tag_cyc, 470);
    pin("u8_msg_steps", n_msg_step, 48);
    pin("u8_msg_cb_high", n_msg_cb, 0);
    pin("u8_accept_cycles", n_wait, 5);
    pin("u8_tag_count", n_tag, 1);

    // UNROLL=4, decrypt, msg=1 with a 50-cycle valid stall
    sel = 1; cur_u = 4; mode_in = 1'b1; cur_dec = 1'b1;
    ad_blocks_in = 16'd0; msg_blocks_in = 16'd1;
    add_idle(1'b1, 1'b0);
    add_run(0, 1, 50);
    run_trace();
    pin("u4_stall_tag_cycle", tag_cyc, 852);
    pin("u4_stall_ready_cycles", n_wait, 51);
    pin("u4_stall_step_count", n_step, 800);

    // UNROLL=8, abort at FINAL step 400, restart two cycles later
    sel = 2; cur_u = 8; mode_in = 1'b1; cur_dec = 1'b1;
    ad_blocks_in = 16'd0; msg_blocks_in = 16'd0;
    add_idle(1'b1, 1'b0);
    add_counted(3'd1, 1792, -1);
    add_counted(3'd3, 256, -1);
    add_counted(3'd5, 256, -1);
    add_counted(3'd6, 768, 50);
    add_idle(1'b0, 1'b0);
    add_idle(1'b1, 1'b0);
    add_run(0, 0, 0);
    run_trace();
    pin("abort_tag_count", n_tag, 1);
    pin("abort_restart_tag_cycle", tag_cyc, 726);

    // Async reset in the middle of INIT, then a fresh run
    add_idle(1'b1, 1'b1);
    add_counted(3'd1, 1792, -1);
    while (trace.size() > 41) void'(trace.pop_back());
    run_trace();
    #2 rst = 1'b1;
    #1 chk_vec("async_rst_outputs", obs, 23'd0);
    @(negedge clk);
    rst = 1'b0;
    add_idle(1'b1, 1'b0);
    add_run(0, 0, 0);
    run_trace();
    pin("post_rst_tag_cycle", tag_cyc, 385);
    pin("post_rst_step_count", n_step, 384);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
